// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// default memory geometry / idle pattern, reused by Inst_Mem and benches.
package inst_mem_loader_pkg;

    localparam int          DEFAULT_MEM_DEPTH = 256;
    localparam logic [31:0] DEFAULT_IDLE_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_TAIL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Assembles four serial bytes (MSB first) into a 32-bit word and flags the
// transfer that completes the word.
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = {word_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o       = word_q;
    // Count wraps to zero on the fourth byte, ready for the next word.
    assign word_valid_o = shift_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Serial program loader: packs bytes into words, writes them from address 0,
// finishes with the idle pattern at the top address and pulses done.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter logic [31:0] IDLE_WORD = DEFAULT_IDLE_WORD,
    localparam int         AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    len_in,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic          abort,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_stall,
    output logic          done,
    output logic          err,
    output logic [31:0]   checksum
);

    state_e        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   chk_q, chk_d;
    logic          err_q, err_d;
    logic          pk_clear;
    logic          pk_shift;
    logic [31:0]   pk_word;
    logic          pk_word_valid;

    function automatic logic [AW-1:0] clamp_len(input logic [7:0] l);
        if ({24'd0, l} >= 32'(MEM_DEPTH)) return AW'(MEM_DEPTH - 1);
        return AW'(l);
    endfunction

    assign pk_shift = byte_valid && byte_ready;

    inst_mem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pk_clear),
        .shift_i      (pk_shift),
        .byte_i       (byte_in),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        chk_d    = chk_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = clamp_len(len_in);
                    addr_d   = '0;
                    chk_d    = '0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                    state_d  = (len_in == 8'd0) ? ST_TAIL : ST_RECV;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    err_d    = 1'b1;
                    pk_clear = 1'b1;
                    state_d  = ST_IDLE;
                end else if (pk_word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The strobe is decoded from the state register, so a word in
                // WRITE is already on the bus; it is accounted for even on abort.
                chk_d  = chk_q ^ pk_word;
                addr_d = addr_q + 1'b1;
                if (abort) begin
                    err_d    = 1'b1;
                    pk_clear = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = (addr_d == len_q) ? ST_TAIL : ST_RECV;
                end
            end
            ST_TAIL: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
        end
    end

    // All handshake and strobe outputs decode the state register only.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            ST_WRITE: begin
                wr_addr = addr_q;
                wr_data = pk_word;
            end
            ST_TAIL: begin
                wr_addr = AW'(MEM_DEPTH - 1);
                wr_data = IDLE_WORD;
            end
            default: ;
        endcase
    end

    assign byte_ready = (state_q == ST_RECV);
    assign wr_en      = (state_q == ST_WRITE) || (state_q == ST_TAIL);
    assign done       = (state_q == ST_DONE);
    assign cpu_stall  = (state_q != ST_IDLE);
    assign err        = err_q;
    assign checksum   = chk_q;

endmodule
